// File: rtl/ram_stream_reader.sv
// ============================================================================
// Module   : ram_stream_reader
// Function : Sweeps (base, length) commands out of a registered-read RAM as a
//            valid/ready stream with full backpressure.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ram_stream_reader #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 64,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    input  logic [DATA_WIDTH-1:0] ram_rddata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [LEN_WIDTH-1:0]  r_remain;
    logic                  r_inflight;
    logic                  r_inflight_last;
    logic [DATA_WIDTH-1:0] r_fifo_data [0:1];
    logic [1:0]            r_fifo_last;
    logic [1:0]            r_count;
    logic                  r_rd_ptr;
    logic                  r_wr_ptr;

    logic                  w_accept;
    logic                  w_pop;
    logic                  w_push;
    logic [2:0]            w_occ;
    logic                  w_issue;
    logic                  w_final_issue;

    assign w_accept      = cmd_valid && cmd_ready;
    assign w_pop         = out_valid && out_ready;
    assign w_push        = r_inflight;
    // Credit counts buffered words plus the read in flight, less this cycle's pop.
    assign w_occ         = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_issue       = (r_state == S_ISSUE) && (w_occ < 3'd2);
    assign w_final_issue = w_issue && (r_remain == '0);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state         <= S_IDLE;
            r_addr          <= '0;
            r_remain        <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
        end else begin
            r_inflight      <= w_issue;
            r_inflight_last <= w_final_issue;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state  <= S_ISSUE;
                        r_addr   <= cmd_addr;
                        r_remain <= cmd_len;
                    end
                end
                S_ISSUE: begin
                    if (w_issue) begin
                        r_addr <= r_addr + 1'b1;
                        if (w_final_issue) begin
                            r_state <= S_DRAIN;
                        end else begin
                            r_remain <= r_remain - 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_pop && out_last) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_fifo_data[0] <= '0;
            r_fifo_data[1] <= '0;
            r_fifo_last    <= '0;
            r_count        <= '0;
            r_rd_ptr       <= 1'b0;
            r_wr_ptr       <= 1'b0;
        end else begin
            if (w_push) begin
                r_fifo_data[r_wr_ptr] <= ram_rddata;
                r_fifo_last[r_wr_ptr] <= r_inflight_last;
                r_wr_ptr              <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    assign cmd_ready = (r_state == S_IDLE);
    assign busy      = !cmd_ready;
    assign ram_addr  = r_addr;
    assign out_valid = (r_count != 2'd0);
    assign out_data  = r_fifo_data[r_rd_ptr];
    assign out_last  = out_valid && r_fifo_last[r_rd_ptr];

endmodule

`default_nettype wire

// File: tb/tb_ram_stream_reader.sv
// ============================================================================
// Module   : tb_ram_stream_reader
// Function : Randomized self-checking bench for ram_stream_reader against a
//            queue-based burst model over a behavioural registered-read RAM.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ram_stream_reader;

    logic        clk;
    logic        rstn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_addr;
    logic [15:0] cmd_len;
    logic [15:0] ram_addr;
    logic [63:0] ram_rddata;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        out_last;
    logic        busy;

    ram_stream_reader #(
        .ADDR_WIDTH (16),
        .DATA_WIDTH (64),
        .LEN_WIDTH  (16)
    ) u_dut (
        .clk        (clk),
        .rstn       (rstn),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_addr   (cmd_addr),
        .cmd_len    (cmd_len),
        .ram_addr   (ram_addr),
        .ram_rddata (ram_rddata),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .busy       (busy)
    );

    logic [63:0] mem [0:65535];
    logic [64:0] exp_q [$];

    int          n_tests = 0;
    int          n_fail  = 0;
    int          ready_mode = 0;
    bit          in_reset = 1'b1;
    time         t_acc;
    bit          first_pending = 1'b0;
    logic [15:0] cur_base = '0;
    int          popped = 0;
    int          max_out = 0;
    bit          streaming = 1'b0;
    bit          expect_idle = 1'b0;
    bit          prev_stall = 1'b0;
    logic [64:0] prev_word = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) ram_rddata <= mem[ram_addr];

    // Mode 0: always ready, 1: random 50%, 2: held low.
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
    end

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rstn && !in_reset) begin
            if (expect_idle) begin
                check("idle_after_last", {busy, cmd_ready}, 2'b01);
                expect_idle = 1'b0;
            end
            if (prev_stall)
                check("stall_hold", {out_valid, out_last, out_data}, {1'b1, prev_word});
            if (streaming)
                check("full_rate", out_valid, 1'b1);
            if (first_pending && out_valid) begin
                check("first_word_latency", $time - t_acc, 25);
                first_pending = 1'b0;
            end
            if (busy) begin
                int outst;
                outst = int'(16'(ram_addr - cur_base)) - popped;
                if (outst > max_out) max_out = outst;
            end
            prev_stall = out_valid && !out_ready;
            prev_word  = {out_last, out_data};
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_word", out_valid, 1'b0);
                end else begin
                    logic [64:0] w;
                    w = exp_q.pop_front();
                    check("word", {out_last, out_data}, w);
                    popped++;
                    if (w[64]) begin
                        check("max_outstanding_le2", (max_out <= 2), 1'b1);
                        expect_idle = 1'b1;
                        streaming   = 1'b0;
                    end else begin
                        streaming = (ready_mode == 0);
                    end
                end
            end
        end
    end

    task automatic send_cmd(input logic [15:0] a, input logic [15:0] l);
        int guard = 0;
        @(negedge clk);
        while (!cmd_ready && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        if (!cmd_ready) begin
            check("cmd_ready_timeout", cmd_ready, 1'b1);
            return;
        end
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_len   = l;
        @(posedge clk);
        t_acc         = $time;
        cur_base      = a;
        popped        = 0;
        max_out       = 0;
        first_pending = 1'b1;
        for (int k = 0; k <= int'(l); k++)
            exp_q.push_back({(k == int'(l)), mem[16'(a + 16'(k))]});
        #1;
        cmd_valid = 1'b0;
        cmd_addr  = 16'($urandom);
        cmd_len   = 16'($urandom);
    endtask

    task automatic wait_done();
        int guard = 0;
        while ((busy || exp_q.size() != 0) && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        check("drain_queue_empty", exp_q.size(), 0);
        check("drain_not_busy", busy, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = {$urandom, 16'($urandom), 16'(i)};
        rstn      = 1'b0;
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_ctrl", {cmd_ready, out_valid, out_last, busy}, 4'b1000);
        check("reset_data", out_data, 64'd0);
        check("reset_addr", ram_addr, 16'd0);
        rstn     = 1'b1;
        in_reset = 1'b0;

        ready_mode = 0;
        send_cmd(16'h0010, 16'd3);
        wait_done();

        send_cmd(16'h0005, 16'd0);
        wait_done();
        check("cmd_ready_after_single", cmd_ready, 1'b1);

        send_cmd(16'hFFFE, 16'd3);
        wait_done();

        ready_mode = 1;
        send_cmd(16'($urandom), 16'd15);
        wait_done();

        ready_mode = 2;
        send_cmd(16'h0200, 16'd15);
        repeat (20) @(negedge clk);
        check("stall_reads_ahead", 16'(ram_addr - cur_base), 16'd2);
        ready_mode = 0;
        wait_done();

        ready_mode = 0;
        send_cmd(16'h0300, 16'd15);
        begin
            int guard = 0;
            while (popped < 3 && guard < 100) begin
                @(negedge clk);
                guard++;
            end
            check("pre_reset_words", (popped >= 3), 1'b1);
        end
        @(posedge clk);
        #2;
        in_reset = 1'b1;
        rstn     = 1'b0;
        #1;
        check("midburst_reset_ctrl", {cmd_ready, out_valid, out_last, busy}, 4'b1000);
        check("midburst_reset_data", out_data, 64'd0);
        check("midburst_reset_addr", ram_addr, 16'd0);
        exp_q.delete();
        prev_stall    = 1'b0;
        streaming     = 1'b0;
        expect_idle   = 1'b0;
        first_pending = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rstn     = 1'b1;
        in_reset = 1'b0;
        send_cmd(16'h1234, 16'd4);
        wait_done();

        repeat (12) begin
            ready_mode = int'($urandom_range(0, 1));
            send_cmd(16'($urandom), 16'($urandom_range(0, 40)));
        end
        wait_done();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
